// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: region/state types, default memory map constants and the address decoder
// shared by the router and its slaves.
package cpu_bus_pkg;

    typedef enum logic [1:0] {SEL_NONE, SEL_PM, SEL_RAM, SEL_IO} sel_t;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [31:0] PROGMEM_MASK_DEF   = 32'h0010_0000;
    localparam logic [31:0] IO_MASK_DEF        = 32'hFF00_0000;
    localparam int          RAM_WORDS_BITS_DEF = 10;
    localparam logic [31:0] ERR_DATA_DEF       = 32'hDEAD_BEEF;

    // IO beats progmem beats RAM; a write into progmem is treated as unmapped.
    function automatic sel_t decode(
        input logic [31:0] addr,
        input logic [3:0]  wstrb,
        input logic [31:0] pm_mask,
        input logic [31:0] io_mask,
        input logic [32:0] ram_bytes
    );
        return |(addr & io_mask)       ? SEL_IO :
               |(addr & pm_mask)       ? (|wstrb ? SEL_NONE : SEL_PM) :
               ({1'b0, addr} < ram_bytes) ? SEL_RAM : SEL_NONE;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts enabled cycles since the last clear and flags the last
// cycle a slave is allowed to take.
module bus_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);

    assign expired = en && cnt == W'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/cpu_bus_router.sv
// cpu_bus_router: routes PicoRV32 native-bus requests to progmem, RAM or MMIO and
// answers unmapped accesses, ROM writes and hung slaves with an error response.
module cpu_bus_router
    import cpu_bus_pkg::*;
#(
    parameter logic [31:0] PROGMEM_MASK   = PROGMEM_MASK_DEF,
    parameter logic [31:0] IO_MASK        = IO_MASK_DEF,
    parameter int          RAM_WORDS_BITS = RAM_WORDS_BITS_DEF,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        pm_valid,
    output logic        ram_valid,
    output logic        io_valid,
    input  logic        pm_ready,
    input  logic        ram_ready,
    input  logic        io_ready,
    input  logic [31:0] pm_rdata,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] io_rdata,
    output logic        err_flag,
    output logic [31:0] err_addr,
    input  logic        err_clr
);
    localparam logic [32:0] RAM_BYTES = 33'd4 << RAM_WORDS_BITS;

    state_t      state, state_nx;
    sel_t        sel, sel_dec;
    logic        sel_ready, busy, expired, err_ev, ok_ev;
    logic [31:0] sel_rdata;

    bus_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (state != BUSY),
        .en      (state == BUSY),
        .expired (expired)
    );

    // Only the selected slave's handshake is looked at, so stray readies are ignored.
    always_comb begin
        sel_dec   = decode(cpu_addr, cpu_wstrb, PROGMEM_MASK, IO_MASK, RAM_BYTES);
        sel_ready = sel == SEL_PM ? pm_ready : sel == SEL_RAM ? ram_ready :
                    sel == SEL_IO ? io_ready : 1'b0;
        sel_rdata = sel == SEL_PM ? pm_rdata : sel == SEL_RAM ? ram_rdata :
                    sel == SEL_IO ? io_rdata : ERR_DATA;
        busy      = state == BUSY && cpu_valid;
        ok_ev     = busy && sel_ready;
        err_ev    = (state == IDLE && cpu_valid && sel_dec == SEL_NONE) ||
                    (busy && !sel_ready && expired);
        state_nx  = state;
        case (state)
            IDLE:    if (cpu_valid) state_nx = sel_dec == SEL_NONE ? RESP : BUSY;
            BUSY:    if (!cpu_valid) state_nx = IDLE;
                     else if (sel_ready || expired) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
        cpu_ready = state == RESP;
        pm_valid  = busy && sel == SEL_PM;
        ram_valid = busy && sel == SEL_RAM;
        io_valid  = busy && sel == SEL_IO;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            sel       <= SEL_NONE;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
            cpu_rdata <= '0;
            err_flag  <= 1'b0;
            err_addr  <= '0;
        end else begin
            if (state == IDLE && cpu_valid) begin
                sel     <= sel_dec;
                s_addr  <= cpu_addr;
                s_wdata <= cpu_wdata;
                s_wstrb <= cpu_wstrb;
            end
            if (ok_ev)
                cpu_rdata <= sel_rdata;
            // A new error outranks a simultaneous clear; err_addr keeps the first one.
            if (err_ev) begin
                cpu_rdata <= ERR_DATA;
                err_flag  <= 1'b1;
                if (!err_flag)
                    err_addr <= state == IDLE ? cpu_addr : s_addr;
            end else if (err_clr)
                err_flag <= 1'b0;
        end

endmodule

// File: tb/tb_cpu_bus_router.sv
// tb_cpu_bus_router: directed vector table plus hand sequences for abandon, clear/error
// collision and asynchronous reset.
module tb_cpu_bus_router;

    localparam logic [31:0] PM_RD  = 32'h0000_0113;
    localparam logic [31:0] RAM_RD = 32'h5555_AAAA;
    localparam logic [31:0] IO_RD  = 32'h0000_C0DE;
    localparam logic [31:0] ERR    = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr, wdata, wstrb, io_en, clr;
        logic [31:0] exp_vmask, exp_vcnt, exp_lat, exp_rdata, exp_flag, exp_eaddr;
    } vec_t;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        cpu_valid = 1'b0, err_clr = 1'b0, io_en = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_ready, pm_valid, ram_valid, io_valid, err_flag;
    logic        pm_ready = 1'b0, ram_ready, io_ready;
    logic [31:0] cpu_rdata, s_addr, s_wdata, err_addr;
    logic [3:0]  s_wstrb;
    int          checks = 0, errors = 0;
    vec_t        vt[8];

    cpu_bus_router #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rstn(rstn), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .pm_valid(pm_valid), .ram_valid(ram_valid), .io_valid(io_valid),
        .pm_ready(pm_ready), .ram_ready(ram_ready), .io_ready(io_ready),
        .pm_rdata(PM_RD), .ram_rdata(RAM_RD), .io_rdata(IO_RD),
        .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Progmem answers one cycle after valid; RAM and MMIO answer in the same cycle.
    always @(posedge clk) pm_ready <= pm_valid && !pm_ready;
    assign ram_ready = ram_valid;
    assign io_ready  = io_valid && io_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xact(input vec_t v);
        int          lat, vc;
        logic [31:0] seen, rd;
        logic        got, first;
        if (v.clr[0]) begin
            @(negedge clk) err_clr = 1'b1;
            @(negedge clk) err_clr = 1'b0;
            chk("err_clr", 32'(err_flag), 0);
        end
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_wstrb = v.wstrb[3:0];
        io_en     = v.io_en[0];
        lat = 0; vc = 0; seen = 0; rd = 0; got = 1'b0; first = 1'b1;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (pm_valid || ram_valid || io_valid) begin
                vc++;
                seen |= {29'd0, io_valid, ram_valid, pm_valid};
                if (first) begin
                    chk("s_addr", s_addr, v.addr);
                    chk("s_wdata", s_wdata, v.wdata);
                    chk("s_wstrb", 32'(s_wstrb), v.wstrb);
                    first = 1'b0;
                end
            end
            if (cpu_ready) begin
                got = 1'b1;
                rd  = cpu_rdata;
                chk("err_flag", 32'(err_flag), v.exp_flag);
                chk("err_addr", err_addr, v.exp_eaddr);
                cpu_valid = 1'b0;
            end
        end
        cpu_valid = 1'b0;
        chk("latency", 32'(lat), v.exp_lat);
        chk("rdata", rd, v.exp_rdata);
        chk("valid_mask", seen, v.exp_vmask);
        chk("valid_cycles", 32'(vc), v.exp_vcnt);
    endtask

    initial begin
        logic rdy_seen;
        // addr, wdata, wstrb, io_en, clr, vmask{io,ram,pm}, vcnt, lat, rdata, flag, eaddr
        vt[0] = '{32'h0010_0010, 0, 0, 0, 0, 1, 2, 3, PM_RD, 0, 0};
        vt[1] = '{32'h0000_0004, 32'h1234_5678, 4'hF, 0, 0, 2, 1, 2, RAM_RD, 0, 0};
        vt[2] = '{32'h0010_0000, 0, 1, 0, 0, 0, 0, 1, ERR, 1, 32'h0010_0000};
        vt[3] = '{32'h0000_1000, 0, 0, 0, 0, 0, 0, 1, ERR, 1, 32'h0010_0000};
        vt[4] = '{32'h0000_0FFC, 0, 0, 0, 1, 2, 1, 2, RAM_RD, 0, 32'h0010_0000};
        vt[5] = '{32'h0400_0000, 0, 0, 1, 0, 4, 1, 2, IO_RD, 0, 32'h0010_0000};
        vt[6] = '{32'h0410_0000, 32'hAA, 3, 1, 0, 4, 1, 2, IO_RD, 0, 32'h0010_0000};
        vt[7] = '{32'h0400_0000, 0, 0, 0, 0, 4, 8, 9, ERR, 1, 32'h0400_0000};

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 0);
        chk("rst_valids", 32'({pm_valid, ram_valid, io_valid}), 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_err_flag", 32'(err_flag), 0);
        chk("rst_err_addr", err_addr, 0);
        rstn = 1'b1;

        foreach (vt[i]) xact(vt[i]);

        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("clr_after_timeout", 32'(err_flag), 0);

        // Abandoned MMIO request: no response, then RAM works normally.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = 32'h0400_0000; cpu_wstrb = 4'h0; io_en = 1'b0;
        @(negedge clk);
        chk("abandon_busy", 32'(io_valid), 1);
        cpu_valid = 1'b0;
        #1 chk("abandon_drop", 32'(io_valid), 0);
        rdy_seen = 1'b0;
        repeat (3) @(negedge clk) rdy_seen |= cpu_ready | io_valid;
        chk("abandon_no_ready", 32'(rdy_seen), 0);
        xact(vec_t'{32'h0000_0008, 0, 0, 0, 0, 2, 1, 2, RAM_RD, 0, 32'h0400_0000});

        // Clear colliding with a new error: the error keeps the flag set.
        xact(vec_t'{32'h0000_1000, 0, 0, 0, 0, 0, 0, 1, ERR, 1, 32'h0000_1000});
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = 32'h0000_2000; cpu_wstrb = 4'h0; err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("collide_ready", 32'(cpu_ready), 1);
        chk("collide_flag", 32'(err_flag), 1);
        chk("collide_addr", err_addr, 32'h0000_1000);
        cpu_valid = 1'b0;

        // Asynchronous reset in the middle of a hung MMIO access.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = 32'h0400_0000; io_en = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(io_valid), 1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_io_valid", 32'(io_valid), 0);
        chk("async_ready", 32'(cpu_ready), 0);
        chk("async_err_flag", 32'(err_flag), 0);
        chk("async_s_addr", s_addr, 0);
        cpu_valid = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'({cpu_ready, pm_valid, ram_valid, io_valid}), 0);
        xact(vec_t'{32'h0000_0010, 0, 0, 0, 0, 2, 1, 2, RAM_RD, 0, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
